// File: rtl/writeback_arbiter_pkg.sv
// Shared CPU definitions: the writeback request carried to the register file
// write port and the architectural register count.
package writeback_arbiter_pkg;

    localparam int REGISTER_COUNT = 32;

    typedef struct packed {
        logic        enabled;
        logic [4:0]  address;
        logic [31:0] data;
    } writeback_request_t;

endpackage

// File: rtl/result_fifo.sv
// Two-entry result buffer for the long-latency unit. Pushes and pops may occur
// in the same cycle; the caller guarantees push only when not full.
module result_fifo
    import writeback_arbiter_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  logic        push_enabled,
    input  logic [4:0]  push_address,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic        head_enabled,
    output logic [4:0]  head_address,
    output logic [31:0] head_data,
    output logic [1:0]  count
);

    writeback_request_t entries [2];
    logic               write_pointer;
    logic               read_pointer;

    // NOTE: the storage array has no reset; count alone says which entries are live,
    // so resetting the data would only add reset fan-out to a RAM-like structure.
    always_ff @(posedge clock) begin
        if (push) begin
            entries[write_pointer] <= '{push_enabled, push_address, push_data};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            write_pointer <= 1'b0;
            read_pointer  <= 1'b0;
            count         <= 2'd0;
        end else begin
            if (push) write_pointer <= ~write_pointer;
            if (pop)  read_pointer  <= ~read_pointer;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head_enabled = entries[read_pointer].enabled;
    assign head_address = entries[read_pointer].address;
    assign head_data    = entries[read_pointer].data;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges pipeline writeback and buffered long-latency results onto the single
// register file write port, with starvation guard and a busy scoreboard.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pipe_valid,
    input  logic        pipe_write_enabled,
    input  logic [4:0]  pipe_address,
    input  logic [31:0] pipe_data,
    output logic        pipe_ready,
    input  logic        long_valid,
    input  logic [4:0]  long_address,
    input  logic [31:0] long_data,
    output logic        long_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_address,
    input  logic [4:0]  read_address_1,
    input  logic [4:0]  read_address_2,
    output logic        busy_1,
    output logic        busy_2,
    output logic        write_enabled,
    output logic [4:0]  write_address,
    output logic [31:0] write_data
);

    localparam int WAIT_WIDTH = $clog2(STARVE_LIMIT + 1);

    logic [1:0]                count;
    logic                      head_enabled;
    logic [4:0]                head_address;
    logic [31:0]               head_data;
    logic [WAIT_WIDTH-1:0]     wait_count;
    logic [REGISTER_COUNT-1:0] busy;
    logic [REGISTER_COUNT-1:0] busy_next;
    logic                      write_from_long;
    logic                      push;
    logic                      pop;
    logic                      pipe_wins;
    writeback_request_t        winner;

    result_fifo buffer (
        .clock        (clock),
        .reset        (reset),
        .push         (push),
        .push_enabled (long_address != 5'd0),
        .push_address (long_address),
        .push_data    (long_data),
        .pop          (pop),
        .head_enabled (head_enabled),
        .head_address (head_address),
        .head_data    (head_data),
        .count        (count)
    );

    assign long_ready = (count != 2'd2);
    assign pipe_ready = (wait_count < WAIT_WIDTH'(STARVE_LIMIT));
    assign push       = long_valid & long_ready;
    assign pipe_wins  = pipe_ready & pipe_valid & pipe_write_enabled & (pipe_address != 5'd0);
    assign pop        = !pipe_wins && (count != 2'd0);

    // NOTE: every variable driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        winner = '0;
        if (pipe_wins) begin
            winner = '{1'b1, pipe_address, pipe_data};
        end else if (pop) begin
            winner = '{head_enabled, head_address, head_data};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            write_enabled   <= 1'b0;
            write_address   <= 5'd0;
            write_data      <= 32'd0;
            write_from_long <= 1'b0;
            wait_count      <= '0;
        end else begin
            write_enabled   <= winner.enabled;
            write_from_long <= pop & head_enabled;
            if (winner.enabled) begin
                write_address <= winner.address;
                write_data    <= winner.data;
            end
            if (pop) begin
                wait_count <= '0;
            end else if (count != 2'd0) begin
                wait_count <= wait_count + WAIT_WIDTH'(1);
            end
        end
    end

    // Clear lands on the edge that stores the long result; a same-cycle issue wins.
    always_comb begin
        busy_next = busy;
        if (write_enabled && write_from_long) busy_next[write_address] = 1'b0;
        if (issue_valid && issue_address != 5'd0) busy_next[issue_address] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign busy_1 = busy[read_address_1];
    assign busy_2 = busy[read_address_2];

endmodule
